// File: rtl/iterative_muldiv_unit_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The master issues operations and the slave (the unit) returns HI/LO results.
interface iterative_muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             divzero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, divzero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, divzero
    );
endinterface

// File: rtl/iterative_muldiv_unit.sv
// Radix-2 multi-cycle MULT/MULTU/DIV/DIVU into HI/LO: one shift-add or
// restoring-divide step per clock, with a start/busy/done handshake.
module iterative_muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    iterative_muldiv_unit_if.slave bus
);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_e;

    state_e           state_q, state_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             divzero_q, divzero_d;

    logic             a_neg, b_neg, div_by_zero;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   mul_sum, rem_sh, trial;
    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] quot, rem;

    // Next-state, datapath step and result fix-up
    always_comb begin
        state_d   = state_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        divzero_d = divzero_q;

        a_neg       = bus.op[0] & bus.a[WIDTH-1];
        b_neg       = bus.op[0] & bus.b[WIDTH-1];
        a_abs       = a_neg ? -bus.a : bus.a;
        b_abs       = b_neg ? -bus.b : bus.b;
        div_by_zero = bus.op[1] && (bus.b == '0);

        mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : '0);
        rem_sh  = {acc_q, mq_q[WIDTH-1]};
        trial   = rem_sh - {1'b0, mcand_q};

        prod = {acc_q, mq_q};
        if (neg_res_q) begin
            prod = -prod;
        end
        quot = neg_res_q ? -mq_q : mq_q;
        rem  = neg_rem_q ? -acc_q : acc_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    is_div_d  = bus.op[1];
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    dz_d      = div_by_zero;
                    cnt_d     = '0;
                    divzero_d = 1'b0;
                    acc_d     = '0;
                    mq_d      = bus.op[1] ? a_abs : b_abs;
                    mcand_d   = bus.op[1] ? b_abs : a_abs;
                    // Divide by zero skips iteration; raw dividend parks in acc for HI
                    if (div_by_zero) begin
                        acc_d   = bus.a;
                        state_d = FINISH;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (is_div_q) begin
                    if (!trial[WIDTH]) begin
                        acc_d = trial[WIDTH-1:0];
                        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = rem_sh[WIDTH-1:0];
                        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (dz_q) begin
                    hi_d      = acc_q;
                    lo_d      = '1;
                    divzero_d = 1'b1;
                end else if (is_div_q) begin
                    hi_d = rem;
                    lo_d = quot;
                end else begin
                    hi_d = prod[PW-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            acc_q     <= '0;
            mq_q      <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.divzero = divzero_q;
endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// Scoreboard bench for iterative_muldiv_unit: expected HI/LO/divzero and done
// cycle are queued at issue time and checked by an independent monitor.
module tb_iterative_muldiv_unit;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    iterative_muldiv_unit_if #(.WIDTH(W)) bus ();

    iterative_muldiv_unit #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          due;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // Reference arithmetic: plain 64-bit products and SV division semantics
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sbv, q, r;
        logic [63:0] p;
        e.dz  = 1'b0;
        e.due = 0;
        e.hi  = '0;
        e.lo  = '0;
        sa    = longint'($signed(a));
        sbv   = longint'($signed(b));
        case (op)
            2'b00: begin
                p = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b01: begin
                p = 64'(sa * sbv);
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.dz = 1'b1;
                    e.hi = a;
                    e.lo = 32'hFFFF_FFFF;
                end else if (op == 2'b10) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end else begin
                    q = sa / sbv;
                    r = sa % sbv;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end
            end
        endcase
        return e;
    endfunction

    // Called at a negedge; returns at the negedge right after the accepting edge E0
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) timeout_fail("issue_wait_idle");
        e = model(op, a, b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        e.due = cyc + (e.dz ? 1 : int'(W) + 1);
        expq.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout_fail("wait_done");
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.done === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                mon_e = expq.pop_front();
                chk("hi", bus.hi, mon_e.hi);
                chk("lo", bus.lo, mon_e.lo);
                chk("divzero", 32'(bus.divzero), 32'(mon_e.dz));
                chk("done_cycle", cyc, mon_e.due);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          n;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_divzero", 32'(bus.divzero), 32'd0);

        // MULTU with busy/done timing traced edge by edge
        issue(2'b00, 32'hFFFF_FFFF, 32'd2);
        chk("busy_e0", 32'(bus.busy), 32'd1);
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            chk("busy_calc", 32'(bus.busy), 32'd1);
            chk("done_early", 32'(bus.done), 32'd0);
        end
        @(negedge clk);
        chk("busy_after_finish", 32'(bus.busy), 32'd0);
        chk("done_after_finish", 32'(bus.done), 32'd1);

        issue(2'b01, 32'hFFFF_FFFD, 32'd5);
        wait_done();
        issue(2'b01, 32'h8000_0000, 32'h8000_0000);
        wait_done();
        issue(2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done();
        issue(2'b10, 32'd100, 32'd7);
        wait_done();
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done();

        // Divide by zero, then the next start clears the flag
        issue(2'b10, 32'd7, 32'd0);
        wait_done();
        issue(2'b00, 32'd3, 32'd4);
        chk("divzero_cleared", 32'(bus.divzero), 32'd0);
        wait_done();

        // Reset mid-operation, with an ignored start at E5
        issue(2'b00, 32'd6, 32'd7);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.a     = 32'd9;
        bus.b     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_ignored_start", 32'(bus.busy), 32'd1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        expq.delete();
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        repeat (40) @(negedge clk);

        // Fresh MULTU, then back-to-back DIVU accepted in its done cycle
        issue(2'b00, 32'd6, 32'd7);
        wait_done();
        issue(2'b10, 32'd9, 32'd3);
        for (int i = 0; i < int'(W); i++) begin
            chk("hold_hi", bus.hi, 32'd0);
            chk("hold_lo", bus.lo, 32'd42);
            @(negedge clk);
        end
        wait_done();

        // Randomized mix including zero, -1 and MIN_INT operands
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            issue(rop, ra, rb);
        end

        n = 0;
        while (expq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) timeout_fail("drain");
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
